// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   tx_state_t    - transmitter FSM states
//   PAR_*         - parity mode encodings used by the PARITY parameter
//   frame_cycles  - clock cycles occupied by one complete frame
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity, input int stop_bits);
    return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_buf
// Synchronous FIFO with registered occupancy count, first-word-fall-through
// read data.
//   clk, reset  - clock and synchronous active-high reset
//   push, wdata - write request and data (ignored while full)
//   pop, rdata  - read request (ignored while empty) and head word
//   full, empty - derived from the registered count
//   count       - number of occupied entries (0..DEPTH)
// ---------------------------------------------------------------------------
module uart_tx_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a pop on the same edge
  // never frees a slot for a push into a full FIFO.
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by a small transmit FIFO. Frames are sent back to
// back while the FIFO holds data; one idle-high CLEANUP cycle follows the
// last frame.
//   i_Clock      - sole clock, rising edge
//   i_Reset      - synchronous active-high reset
//   i_Tx_DV      - write strobe, accepted while o_Tx_Ready is high
//   i_Tx_Byte    - data word, LSB first on the line
//   o_Tx_Ready   - FIFO not full
//   o_Fifo_Count - occupied FIFO entries
//   o_Tx_Active  - high while a frame is on the line
//   o_Tx_Serial  - registered serial line, idle high
//   o_Tx_Done    - one-cycle pulse at the end of every frame
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_t                 state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [IDX_W-1:0]          idx, idx_next;
  logic [DATA_BITS-1:0]      tx_data;
  logic [DATA_BITS-1:0]      fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      bit_end;
  logic                      done_next;
  logic                      serial_next;
  logic                      active_next;

  uart_tx_fifo_buf #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (i_Clock),
    .reset (i_Reset),
    .push  (i_Tx_DV),
    .pop   (pop),
    .wdata (i_Tx_Byte),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_Fifo_Count)
  );

  assign o_Tx_Ready = !fifo_full;
  assign bit_end    = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  // State register; the line outputs are registered from the next-state
  // decode so they change on the same edge as the state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      tx_data     <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      if (pop) tx_data <= fifo_rdata;
      o_Tx_Serial <= serial_next;
      o_Tx_Active <= active_next;
      o_Tx_Done   <= done_next;
    end
  end

  // Next-state decode. idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = bit_end ? '0 : cnt + 1'b1;
    pop        = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_next   = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idx_next   = '0;
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          idx_next   = '0;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            done_next = 1'b1;
            idx_next  = '0;
            // Chain straight into the next frame when more data is queued.
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = ST_START;
            end else begin
              state_next = ST_CLEANUP;
            end
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_CLEANUP: begin
        cnt_next   = '0;
        idx_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle. tx_data is only consulted for DATA and
  // PARITY, which are never entered on the edge that loads it.
  always_comb begin
    serial_next = 1'b1;
    active_next = 1'b0;
    unique case (state_next)
      ST_START: begin
        serial_next = 1'b0;
        active_next = 1'b1;
      end
      ST_DATA: begin
        serial_next = tx_data[idx_next];
        active_next = 1'b1;
      end
      ST_PARITY: begin
        serial_next = (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
        active_next = 1'b1;
      end
      ST_STOP: begin
        active_next = 1'b1;
      end
      default: begin
        serial_next = 1'b1;
        active_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Two transmitters: an 8E1 instance and a 7O2 instance, both with four clocks
// per bit and a four-entry FIFO. A queue-based model predicts every output
// from the frame layout; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB    = 4;
  localparam int DEPTH  = 4;
  localparam int DB1    = 8;
  localparam int PAR1   = PAR_EVEN;
  localparam int SB1    = 1;
  localparam int DB2    = 7;
  localparam int PAR2   = PAR_ODD;
  localparam int SB2    = 2;
  localparam int FRAME1 = frame_cycles(CPB, DB1, PAR1, SB1);
  localparam int FRAME2 = frame_cycles(CPB, DB2, PAR2, SB2);

  logic       clock = 1'b0;
  logic       reset;
  logic       dv1, dv2;
  logic [7:0] byte1;
  logic [6:0] byte2;
  logic       ready1, ready2;
  logic [2:0] count1, count2;
  logic       active1, active2;
  logic       serial1, serial2;
  logic       done1, done2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (DB1), .PARITY (PAR1),
    .STOP_BITS (SB1), .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_Clock (clock), .i_Reset (reset), .i_Tx_DV (dv1), .i_Tx_Byte (byte1),
    .o_Tx_Ready (ready1), .o_Fifo_Count (count1), .o_Tx_Active (active1),
    .o_Tx_Serial (serial1), .o_Tx_Done (done1)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (DB2), .PARITY (PAR2),
    .STOP_BITS (SB2), .FIFO_DEPTH (DEPTH)
  ) dut2 (
    .i_Clock (clock), .i_Reset (reset), .i_Tx_DV (dv2), .i_Tx_Byte (byte2),
    .o_Tx_Ready (ready2), .o_Fifo_Count (count2), .o_Tx_Active (active2),
    .o_Tx_Serial (serial2), .o_Tx_Done (done2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  // Line level at bit slot k of a frame carrying word.
  function automatic logic frameBit(input logic [7:0] word, input int k,
                                    input int db, input int par);
    int ones;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= db) return word[k-1];
    if (par != PAR_NONE && k == db + 1) begin
      for (int i = 0; i < db; i++) ones += int'(word[i]);
      return (par == PAR_EVEN) ? ones[0] : ~ones[0];
    end
    return 1'b1;
  endfunction

  // Model: a queue of waiting words plus "cycles into the current frame".
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] word1, word2;
  bit         busy1, busy2, clean1, clean2, room1, room2, exp_done1, exp_done2;
  int         pos1, pos2;
  bit         model_valid = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      q1.delete(); q2.delete();
      busy1 = 0; busy2 = 0; clean1 = 0; clean2 = 0;
      exp_done1 = 0; exp_done2 = 0; pos1 = 0; pos2 = 0;
      model_valid = 1'b1;
    end else begin
      room1 = (q1.size() < DEPTH);
      exp_done1 = 0;
      if (busy1) begin
        pos1++;
        if (pos1 == FRAME1) begin
          exp_done1 = 1;
          if (q1.size() > 0) begin word1 = q1.pop_front(); pos1 = 0; end
          else begin busy1 = 0; clean1 = 1; end
        end
      end else if (clean1) begin
        clean1 = 0;
      end else if (q1.size() > 0) begin
        word1 = q1.pop_front(); busy1 = 1; pos1 = 0;
      end
      if (dv1 && room1) q1.push_back(byte1);

      room2 = (q2.size() < DEPTH);
      exp_done2 = 0;
      if (busy2) begin
        pos2++;
        if (pos2 == FRAME2) begin
          exp_done2 = 1;
          if (q2.size() > 0) begin word2 = q2.pop_front(); pos2 = 0; end
          else begin busy2 = 0; clean2 = 1; end
        end
      end else if (clean2) begin
        clean2 = 0;
      end else if (q2.size() > 0) begin
        word2 = q2.pop_front(); busy2 = 1; pos2 = 0;
      end
      if (dv2 && room2) q2.push_back({1'b0, byte2});
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("serial1", serial1, busy1 ? frameBit(word1, pos1 / CPB, DB1, PAR1) : 1'b1);
      checkOutput("active1", active1, busy1);
      checkOutput("done1",   done1,   exp_done1);
      checkOutput("count1",  count1,  q1.size());
      checkOutput("ready1",  ready1,  q1.size() < DEPTH);
      checkOutput("serial2", serial2, busy2 ? frameBit(word2, pos2 / CPB, DB2, PAR2) : 1'b1);
      checkOutput("active2", active2, busy2);
      checkOutput("done2",   done2,   exp_done2);
      checkOutput("count2",  count2,  q2.size());
      checkOutput("ready2",  ready2,  q2.size() < DEPTH);
    end
  end

  task automatic applyStimulus(input logic [7:0] w1, input logic en1,
                               input logic [6:0] w2, input logic en2);
    @(posedge clock);
    #1;
    dv1 = en1; byte1 = w1;
    dv2 = en2; byte2 = w2;
  endtask

  task automatic releaseInputs();
    @(posedge clock);
    #1;
    dv1 = 1'b0;
    dv2 = 1'b0;
  endtask

  // Samples each bit slot mid-bit, starting at the cycle after the start edge.
  task automatic captureFrames(output logic [10:0] fr1, output logic [10:0] fr2,
                               output int early);
    early = 0;
    fr1 = '0;
    fr2 = '0;
    for (int c = 0; c < 11 * CPB; c++) begin
      @(negedge clock);
      if (done1 || done2) early++;
      if (c % CPB == 1) begin
        fr1[c / CPB] = serial1;
        fr2[c / CPB] = serial2;
      end
    end
  endtask

  logic [10:0] f1, f2;
  int          early, n, act;
  int          t[3];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dv1 = 0; byte1 = '0; dv2 = 0; byte2 = '0; reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_serial", serial1, 1'b1);
    checkOutput("reset_active", active1, 1'b0);
    checkOutput("reset_count",  count1,  3'd0);
    checkOutput("reset_ready",  ready1,  1'b1);
    checkOutput("model_frame_len1", FRAME1, 44);
    checkOutput("model_frame_len2", FRAME2, 44);

    // Single frames: 0xA5 on 8E1, 0x7F on 7O2.
    applyStimulus(8'hA5, 1'b1, 7'h7F, 1'b1);
    releaseInputs();
    @(negedge clock);
    checkOutput("prestart_serial", serial1, 1'b1);
    checkOutput("prestart_count",  count1,  3'd1);
    captureFrames(f1, f2, early);
    checkOutput("frame_a5",     f1, 11'b10101001010);
    checkOutput("frame_7f_odd", f2, 11'b11011111110);
    checkOutput("early_done",   early, 0);
    @(negedge clock);
    checkOutput("done_a5_at_44", done1, 1'b1);
    checkOutput("done_7f_at_44", done2, 1'b1);
    checkOutput("cleanup_active", active1, 1'b0);
    @(negedge clock);
    checkOutput("done_a5_single", done1, 1'b0);

    // Three words pushed back to back; window index 0 is frame cycle 1.
    repeat (4) @(negedge clock);
    applyStimulus(8'h01, 1'b1, 7'h00, 1'b0);
    applyStimulus(8'h02, 1'b1, 7'h00, 1'b0);
    applyStimulus(8'h03, 1'b1, 7'h00, 1'b0);
    releaseInputs();
    n = 0; act = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (active1) act++;
      if (done1) begin
        if (n < 3) t[n] = c;
        n++;
      end
    end
    checkOutput("b2b_done_count", n, 3);
    checkOutput("b2b_first_done", t[0], 43);
    checkOutput("b2b_gap1", t[1] - t[0], 44);
    checkOutput("b2b_gap2", t[2] - t[1], 44);
    checkOutput("b2b_active_cycles", act, 131);

    // Six pushes while idle: one popped, four fill the FIFO, sixth dropped.
    for (int i = 0; i < 6; i++) applyStimulus(8'h10 + 8'(i), 1'b1, 7'h00, 1'b0);
    releaseInputs();
    @(negedge clock);
    checkOutput("full_count", count1, 3'd4);
    checkOutput("full_ready", ready1, 1'b0);
    n = 0;
    for (int c = 0; c < 5 * 44 + 20; c++) begin
      @(negedge clock);
      if (done1) n++;
    end
    checkOutput("full_frames", n, 5);

    // Reset in the middle of the data bits, with a push in the reset cycle.
    applyStimulus(8'hFF, 1'b1, 7'h00, 1'b0);
    applyStimulus(8'h33, 1'b1, 7'h00, 1'b0);
    releaseInputs();
    repeat (12) @(posedge clock);
    #1;
    reset = 1'b1; dv1 = 1'b1; byte1 = 8'h99;
    @(posedge clock);
    #1;
    reset = 1'b0; dv1 = 1'b0;
    @(negedge clock);
    checkOutput("abort_serial", serial1, 1'b1);
    checkOutput("abort_active", active1, 1'b0);
    checkOutput("abort_done",   done1,   1'b0);
    checkOutput("abort_count",  count1,  3'd0);
    checkOutput("abort_ready",  ready1,  1'b1);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done1) n++;
    end
    checkOutput("abort_no_done", n, 0);

    applyStimulus(8'h55, 1'b1, 7'h00, 1'b0);
    releaseInputs();
    @(negedge clock);
    captureFrames(f1, f2, early);
    checkOutput("frame_55", f1, 11'b10010101010);
    @(negedge clock);
    checkOutput("done_55", done1, 1'b1);

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87: clock cycles per serial bit, legal range >= 2.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, >= 2.
REQ-006 i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-007 i_Reset  input  1  synchronous, active-high reset.
REQ-008 i_Tx_DV  input  1  write strobe; pushes i_Tx_Byte when o_Tx_Ready is high.
REQ-009 i_Tx_Byte  input  DATA_BITS  data word, LSB transmitted first.
REQ-010 o_Tx_Ready  output  1  FIFO not full.
REQ-011 o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
REQ-012 o_Tx_Active  output  1  high while a frame is on the line.
REQ-013 o_Tx_Serial  output  1  registered serial line; idle high.
REQ-014 o_Tx_Done  output  1  one-cycle pulse per completed frame.

Function
REQ-015 A push occurs on an edge where i_Tx_DV=1 and o_Tx_Ready=1; with o_Tx_Ready=0 the word is dropped and FIFO state is unchanged.
REQ-016 o_Tx_Ready and o_Fifo_Count reflect registered state; a pop on the same edge does not make room for a push when the FIFO is full.
REQ-017 A simultaneous push and pop on a non-full FIFO leaves o_Fifo_Count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 The FSM has the states IDLE, START, DATA, PARITY, STOP and CLEANUP.
REQ-019 In IDLE with the FIFO non-empty, the next edge pops the head word, enters START, drives o_Tx_Serial=0 and sets o_Tx_Active=1.
REQ-020 START lasts CLKS_PER_BIT cycles, then transitions to DATA.
REQ-021 DATA sends bits 0..DATA_BITS-1, each for CLKS_PER_BIT cycles, then transitions to PARITY if PARITY!=0, else to STOP.
REQ-022 PARITY drives XOR of the data bits for even parity, or its inverse for odd parity, for CLKS_PER_BIT cycles.
REQ-023 STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 Total frame length is exactly CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles from the start-bit edge.
REQ-025 At the end of STOP, o_Tx_Done pulses high for exactly one cycle.
REQ-026 At the end of STOP, if the FIFO is non-empty, the FSM pops and re-enters START on the same edge with no idle gap, and o_Tx_Active stays high.
REQ-027 At the end of STOP, if the FIFO is empty, the FSM enters CLEANUP for one cycle with o_Tx_Active=0 and the line high, then enters IDLE.
REQ-028 The popped word is latched internally, so FIFO pushes during a frame do not alter the frame in flight.
REQ-029 The bit-period counter is $clog2(CLKS_PER_BIT) bits wide and is cleared at every bit boundary.

Reset
REQ-030 On the edge with i_Reset=1: FSM to IDLE, FIFO emptied, counters cleared, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1.
REQ-031 Reset mid-frame aborts the frame immediately; no o_Tx_Done is produced, and a push in the reset cycle is ignored.

Structure
REQ-032 Package uart_pkg shall hold the FSM state enum, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the frame-length function.
REQ-033 The FIFO shall be a sub-module uart_tx_fifo_buf (parameter DEPTH, WIDTH) with push, pop, full, empty and count ports.

Verification
REQ-034 Bench parameters: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1.
- Push 0xA5 into an idle block -> line 0, 1,0,1,0,0,1,0,1, parity 0, 1; 4 cycles per bit; o_Tx_Done pulses once 44 cycles after the start edge.
- Push 0x01, 0x02, 0x03 on consecutive cycles -> three back-to-back frames with no idle cycle between them, three o_Tx_Done pulses spaced 44 cycles apart.
- Push 6 words while idle with FIFO_DEPTH=4 -> the 1st word is popped and words 2..5 fill the FIFO; o_Tx_Ready=0, the 6th word is dropped, o_Fifo_Count=4, and 5 frames are transmitted.
- PARITY=1, DATA_BITS=7, STOP_BITS=2, push 0x7F -> odd parity bit 0, two stop bits, 44-cycle frame.
- Assert i_Reset in the middle of the DATA state -> o_Tx_Serial=1 next cycle, no o_Tx_Done, o_Fifo_Count=0; a later push of 0x55 transmits correctly.
